alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU in the execute stage.
- Keeps the single-cycle opcode set and adds arithmetic right shift, pass-through, iterative unsigned multiply and iterative unsigned divide/remainder.
- Registers its result behind a valid/ready handshake so the pipeline can stall on long operations.
- Sits between the ID/EX pipeline register and the EX/MEM register.

Parameters:
- WIDTH, 32, operand and result width; must be ≥4 and a power of two.
- MULDIV_EN, 1, 1 = multiply/divide opcodes iterate; 0 = they complete in one cycle with result 0.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  block can accept an operation this cycle.
- alu_op1  input  WIDTH  operand A, sampled on accept.
- alu_op2  input  WIDTH  operand B, sampled on accept.
- alu_ctrl  input  4  opcode, sampled on accept.
- flush  input  1  synchronous kill of the in-flight operation.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- alu_res  output  WIDTH  result, registered.
- of  output  1  signed overflow flag, registered.
- busy  output  1  high while in BUSY state.

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous and active-low.
- Reset values: out_valid=0, alu_res=0, of=0, busy=0, state=IDLE. in_ready is 1 once rstn is deasserted.
- Opcodes, single-cycle group:
  - 0000 add; of = signed overflow.
  - 0001 sub; of = signed overflow.
  - 0010 eq: 1 if A==B.
  - 0011 sltu.
  - 0100 slt (signed).
  - 0101 and, 0110 or, 0111 xor.
  - 1000 sll, 1001 srl, 1010 sra.
  - 1111 pass: result = B.
- Opcodes, multi-cycle group:
  - 1011 mul: low WIDTH bits of A*B.
  - 1100 mulhu: high WIDTH bits of unsigned A*B.
  - 1101 divu: quotient.
  - 1110 remu: remainder.
- Shifts use only B[log2(WIDTH)-1:0]; upper bits are ignored.
- of is 0 for every opcode except add and sub.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A new operation may therefore be accepted in the same cycle the current result is consumed.
- State machine, three states: IDLE, BUSY, DONE.
  - IDLE, accept of a single-cycle op: compute, register result, go to DONE.
  - IDLE, accept of a multi-cycle op with MULDIV_EN=1: load operands, clear iteration counter, go to BUSY.
  - BUSY: one radix-2 shift-add (mul) or restoring-subtract (div) step per cycle for exactly WIDTH cycles. After the last step, register the result and go to DONE.
  - DONE: out_valid=1.
    - out_ready=1 with a new accept: process the new op as from IDLE.
    - out_ready=1 without an accept: go to IDLE.
    - out_ready=0: hold alu_res and of stable.
- Latency, with accept in cycle N:
  - single-cycle ops: out_valid in cycle N+1.
  - multi-cycle ops: out_valid in cycle N+WIDTH+1.
- Multiply uses an unsigned 2*WIDTH-bit product; mul and mulhu differ only in the half selected.
- Divide by zero: quotient = all ones, remainder = A. Full WIDTH-cycle latency still applies and there is no exception.
- flush (synchronous, highest priority after reset): next state IDLE, out_valid=0; any accept in the same cycle is ignored. alu_res keeps its last value.
- rstn asserted mid-operation: immediate return to reset values; the partial result is discarded.
- Unknown opcodes: none exist, since all 16 encodings are defined.
- in_valid held high while in_ready=0: no effect, and operands are not re-sampled.

Test Plan:
- Add overflow: add 0x7FFFFFFF + 0x00000001 accepted in cycle 0 → cycle 1: out_valid=1, alu_res=0x80000000, of=1. Then sub 0x80000000 − 1 → 0x7FFFFFFF, of=1.
- Arithmetic right shift: sra 0x80000000 by B=0x00000024 (shift amount 4) → 0xF8000000. srl with the same inputs → 0x08000000. slt 0xFFFFFFFF vs 1 → 1; sltu with the same inputs → 0.
- Multiply: mul 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001 with out_valid exactly 33 cycles after accept and busy high for 32 cycles. mulhu with the same inputs → 0xFFFFFFFE.
- Divide: divu 100/7 → 14; remu 100/7 → 2. Divide by zero: divu 5/0 → 0xFFFFFFFF; remu 5/0 → 5; latency is still 33 cycles.
- Backpressure: hold out_ready=0 for 3 cycles after a result → alu_res, of and out_valid stay stable and in_ready=0. Then raise out_ready together with a new add in_valid → new result appears the next cycle with no bubble.
- Flush and reset: flush in cycle 10 of a divu → no out_valid and in_ready=1 the following cycle. Drop rstn mid-mul → out_valid, alu_res, of and busy go to 0 immediately. After release, a fresh add completes normally.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith ops plus iterative
// unsigned multiply and divide, with the result registered behind valid/ready.
module alu_mc #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_op1,
  input  logic [WIDTH-1:0] alu_op2,
  input  logic [3:0]       alu_ctrl,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_res,
  output logic             of,
  output logic             busy
);

  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpEq    = 4'b0010;
  localparam logic [3:0] OpSltu  = 4'b0011;
  localparam logic [3:0] OpSlt   = 4'b0100;
  localparam logic [3:0] OpAnd   = 4'b0101;
  localparam logic [3:0] OpOr    = 4'b0110;
  localparam logic [3:0] OpXor   = 4'b0111;
  localparam logic [3:0] OpSll   = 4'b1000;
  localparam logic [3:0] OpSrl   = 4'b1001;
  localparam logic [3:0] OpSra   = 4'b1010;
  localparam logic [3:0] OpMul   = 4'b1011;
  localparam logic [3:0] OpMulhu = 4'b1100;
  localparam logic [3:0] OpDivu  = 4'b1101;
  localparam logic [3:0] OpRemu  = 4'b1110;
  localparam logic [3:0] OpPass  = 4'b1111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             of_q, of_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [3:0]       op_q, op_d;
  logic [ShW-1:0]   cnt_q, cnt_d;

  logic             accept;
  logic             start_multi;
  logic             op_is_mul;
  logic [WIDTH-1:0] sum, diff;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_of;

  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             step_last;
  logic [WIDTH-1:0] multi_res;

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = valid_q;
  assign alu_res   = res_q;
  assign of        = of_q;
  assign busy      = (state_q == StBusy);

  assign start_multi = MULDIV_EN && (alu_ctrl inside {OpMul, OpMulhu, OpDivu, OpRemu});
  assign op_is_mul   = (op_q == OpMul) || (op_q == OpMulhu);

  assign sum   = alu_op1 + alu_op2;
  assign diff  = alu_op1 - alu_op2;
  assign shamt = alu_op2[ShW-1:0];

  // Single-cycle result; the mul/div encodings fall to zero here.
  always_comb begin
    sc_res = '0;
    sc_of  = 1'b0;
    case (alu_ctrl)
      OpAdd: begin
        sc_res = sum;
        sc_of  = (alu_op1[WIDTH-1] == alu_op2[WIDTH-1]) && (sum[WIDTH-1] != alu_op1[WIDTH-1]);
      end
      OpSub: begin
        sc_res = diff;
        sc_of  = (alu_op1[WIDTH-1] != alu_op2[WIDTH-1]) && (diff[WIDTH-1] != alu_op1[WIDTH-1]);
      end
      OpEq:   sc_res = WIDTH'(alu_op1 == alu_op2);
      OpSltu: sc_res = WIDTH'(alu_op1 < alu_op2);
      OpSlt:  sc_res = WIDTH'($signed(alu_op1) < $signed(alu_op2));
      OpAnd:  sc_res = alu_op1 & alu_op2;
      OpOr:   sc_res = alu_op1 | alu_op2;
      OpXor:  sc_res = alu_op1 ^ alu_op2;
      OpSll:  sc_res = alu_op1 << shamt;
      OpSrl:  sc_res = alu_op1 >> shamt;
      OpSra:  sc_res = $signed(alu_op1) >>> shamt;
      OpPass: sc_res = alu_op2;
      default: sc_res = '0;
    endcase
  end

  // One iteration step. mul: {hi,lo} is the partial product with the
  // multiplier shifting out of lo. div: hi is the running remainder and the
  // dividend shifts out of lo while quotient bits shift in.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_is_mul) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      step_hi = div_diff[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], 1'b0};
    end
    step_last = (cnt_q == ShW'(WIDTH - 1));
    multi_res = ((op_q == OpMulhu) || (op_q == OpRemu)) ? step_hi : step_lo;
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    of_d    = of_q;
    valid_d = valid_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle, StDone: begin
        if ((state_q == StDone) && out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
        if (accept) begin
          op_d = alu_ctrl;
          if (start_multi) begin
            state_d = StBusy;
            valid_d = 1'b0;
            cnt_d   = '0;
            hi_d    = '0;
            if ((alu_ctrl == OpMul) || (alu_ctrl == OpMulhu)) begin
              lo_d   = alu_op2;
              opnd_d = alu_op1;
            end else begin
              lo_d   = alu_op1;
              opnd_d = alu_op2;
            end
          end else begin
            state_d = StDone;
            valid_d = 1'b1;
            res_d   = sc_res;
            of_d    = sc_of;
          end
        end
      end
      StBusy: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (step_last) begin
          state_d = StDone;
          valid_d = 1'b1;
          res_d   = multi_res;
          of_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d = StIdle;
      valid_d = 1'b0;
      res_d   = res_q;
      of_d    = of_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      res_q   <= '0;
      of_q    <= 1'b0;
      valid_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      of_q    <= of_d;
      valid_q <= valid_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_alu_mc;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] alu_op1;
  logic [W-1:0] alu_op2;
  logic [3:0]   alu_ctrl;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_res;
  logic         of;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_mc #(
    .WIDTH    (W),
    .MULDIV_EN(1'b1)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op1  (alu_op1),
    .alu_op2  (alu_op2),
    .alu_ctrl (alu_ctrl),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_res  (alu_res),
    .of       (of),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {of, result}.
  function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [2*W-1:0] p;
    longint         sa, sb, s, lim;
    int             sh;
    logic [W-1:0]   r;
    logic           o;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    sh  = int'(b % W);
    p   = (2*W)'(a) * (2*W)'(b);
    o   = 1'b0;
    r   = '0;
    case (op)
      4'd0: begin s = sa + sb; r = W'(s); o = (s >= lim) || (s < -lim); end
      4'd1: begin s = sa - sb; r = W'(s); o = (s >= lim) || (s < -lim); end
      4'd2: r = W'(a == b);
      4'd3: r = W'(a < b);
      4'd4: r = W'(sa < sb);
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8: r = a << sh;
      4'd9: r = a >> sh;
      4'd10: r = W'($signed(a) >>> sh);
      4'd11: r = p[W-1:0];
      4'd12: r = p[2*W-1:W];
      4'd13: r = (b == 0) ? '1 : a / b;
      4'd14: r = (b == 0) ? a : a % b;
      default: r = b;
    endcase
    return {o, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one op with out_ready high, waits for the result and checks it.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    logic [W:0] exp;
    int         lat, busy_cycles, guard;
    bit         multi;
    exp   = model(op, a, b);
    multi = (op >= 4'd11) && (op <= 4'd14);
    out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    in_valid = 1'b1;
    alu_ctrl = op;
    alu_op1  = a;
    alu_op2  = b;
    step();
    in_valid    = 1'b0;
    lat         = 1;
    busy_cycles = 0;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cycles++;
      step();
      lat++;
    end
    check_eq($sformatf("%s.lat", tag), 64'(lat), multi ? 64'(W + 1) : 64'd1);
    check_eq($sformatf("%s.res", tag), 64'(alu_res), 64'(exp[W-1:0]));
    check_eq($sformatf("%s.of", tag), 64'(of), 64'(exp[W]));
    if (multi) check_eq($sformatf("%s.busy", tag), 64'(busy_cycles), 64'(W));
  endtask

  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    int           seen;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    alu_op1   = '0;
    alu_op2   = '0;
    alu_ctrl  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    check_eq("rst.valid", 64'(out_valid), 64'd0);
    check_eq("rst.res", 64'(alu_res), 64'd0);
    check_eq("rst.of", 64'(of), 64'd0);
    check_eq("rst.busy", 64'(busy), 64'd0);
    rstn = 1'b1;
    step();
    check_eq("rst.ready", 64'(in_ready), 64'd1);

    run_op(4'd0, 32'h7FFF_FFFF, 32'h1, "add_ovf");
    run_op(4'd1, 32'h8000_0000, 32'h1, "sub_ovf");
    run_op(4'd10, 32'h8000_0000, 32'h24, "sra");
    run_op(4'd9, 32'h8000_0000, 32'h24, "srl");
    run_op(4'd4, 32'hFFFF_FFFF, 32'h1, "slt");
    run_op(4'd3, 32'hFFFF_FFFF, 32'h1, "sltu");
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul");
    run_op(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(4'd13, 32'd100, 32'd7, "divu");
    run_op(4'd14, 32'd100, 32'd7, "remu");
    run_op(4'd13, 32'd5, 32'd0, "divu0");
    run_op(4'd14, 32'd5, 32'd0, "remu0");
    run_op(4'd15, 32'h1234_5678, 32'hCAFE_F00D, "pass");

    // Backpressure; operands offered while stalled must not be re-sampled.
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_ctrl  = 4'd0;
    alu_op1   = 32'd5;
    alu_op2   = 32'd6;
    step();
    alu_op1 = 32'd100;
    check_eq("bp.valid0", 64'(out_valid), 64'd1);
    check_eq("bp.res0", 64'(alu_res), 64'd11);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp.valid", 64'(out_valid), 64'd1);
      check_eq("bp.res", 64'(alu_res), 64'd11);
      check_eq("bp.of", 64'(of), 64'd0);
      check_eq("bp.ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    alu_op1   = 32'h7FFF_FFFF;
    alu_op2   = 32'h1;
    #1;
    check_eq("bp.ready_hi", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check_eq("bp.valid_new", 64'(out_valid), 64'd1);
    check_eq("bp.res_new", 64'(alu_res), 64'h8000_0000);
    check_eq("bp.of_new", 64'(of), 64'd1);

    // Flush in the 10th busy cycle of a divide.
    in_valid = 1'b1;
    alu_ctrl = 4'd13;
    alu_op1  = 32'd100;
    alu_op2  = 32'd7;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    flush    = 1'b1;
    in_valid = 1'b1;
    alu_ctrl = 4'd0;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("fl.valid", 64'(out_valid), 64'd0);
    check_eq("fl.ready", 64'(in_ready), 64'd1);
    check_eq("fl.busy", 64'(busy), 64'd0);
    check_eq("fl.res_kept", 64'(alu_res), 64'h8000_0000);
    seen = 0;
    for (int i = 0; i < int'(W) + 4; i++) begin
      step();
      if (out_valid) seen++;
    end
    check_eq("fl.no_valid", 64'(seen), 64'd0);

    // Flush while idle: the simultaneous accept is dropped.
    in_valid = 1'b1;
    flush    = 1'b1;
    alu_ctrl = 4'd0;
    alu_op1  = 32'd1;
    alu_op2  = 32'd2;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    check_eq("fl.idle_valid", 64'(out_valid), 64'd0);
    check_eq("fl.idle_res", 64'(alu_res), 64'h8000_0000);

    // Asynchronous reset mid-multiply.
    in_valid = 1'b1;
    alu_ctrl = 4'd11;
    alu_op1  = 32'hFFFF_FFFF;
    alu_op2  = 32'hFFFF_FFFF;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rstn = 1'b0;
    #1;
    check_eq("mr.valid", 64'(out_valid), 64'd0);
    check_eq("mr.res", 64'(alu_res), 64'd0);
    check_eq("mr.of", 64'(of), 64'd0);
    check_eq("mr.busy", 64'(busy), 64'd0);
    #3;
    rstn = 1'b1;
    step();
    run_op(4'd0, 32'd40, 32'd2, "post_rst_add");

    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 5) == 0) ra = rb;
      run_op(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
